// File: rtl/ilm_loader_pkg.sv
// Shared definitions for the ILM preload engine: FSM state encoding and
// the widths of the ILM write word and its SEC-DED check field.
package ilm_loader_pkg;

    localparam int ILM_WDATA_W = 40;
    localparam int ECC_W       = 7;

    // FSM state encoding, kept as plain constants so legacy tools can read it
    typedef logic [2:0] ilm_state_t;

    localparam ilm_state_t ST_IDLE  = 3'd0;
    localparam ilm_state_t ST_CLEAR = 3'd1;
    localparam ilm_state_t ST_LOAD  = 3'd2;
    localparam ilm_state_t ST_FLUSH = 3'd3;
    localparam ilm_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/ilm_ecc_enc32.sv
// SEC-DED encoder for one 32-bit ILM word (39,32 extended Hamming).
// Data bits occupy the non-power-of-two positions 3..38 of the codeword;
// p0..p5 cover the positions whose index has the matching bit set, and
// p6 is overall parity over the data and p0..p5. Shared with the checker.
module ilm_ecc_enc32
    import ilm_loader_pkg::*;
(
    input  logic [31:0]      data_i,
    output logic [ECC_W-1:0] ecc_o
);

    // Codeword position (1-based) of data bit idx
    function automatic logic [5:0] data_pos(input int idx);
        int         n;
        logic [5:0] r;
        n = 0;
        r = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = 6'(p);
                n++;
            end
        end
        return r;
    endfunction

    logic [5:0] par;
    logic [5:0] pos;

    // Hamming parities plus overall parity, purely combinational
    always_comb begin
        par = '0;
        pos = '0;
        for (int i = 0; i < 32; i++) begin
            pos = data_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) par[k] = par[k] ^ data_i[i];
            end
        end
        ecc_o = {(^data_i) ^ (^par), par};
    end

endmodule

// File: rtl/ilm_stream_loader.sv
// ILM preload engine. On start it zero-fills the whole ILM, then packs a
// little-endian byte stream into 32-bit words with SEC-DED check bits and
// writes them from word 0 upward, holding the core in reset meanwhile.
module ilm_stream_loader
    import ilm_loader_pkg::*;
#(
    parameter int RAM_DP  = 4096,
    parameter int AW      = $clog2(RAM_DP),
    parameter bit HAS_ECC = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   ilm_cs,
    output logic                   ilm_we,
    output logic [AW-1:0]          ilm_addr,
    output logic [ILM_WDATA_W-1:0] ilm_wdata,
    input  logic                   ilm_gnt,
    output logic                   busy,
    output logic                   core_hold,
    output logic                   done,
    output logic                   err_ovf
);

    // One extra address bit so the counter can express "ILM full"
    localparam logic [AW:0] ADDR_END  = (AW + 1)'(RAM_DP);
    localparam logic [AW:0] ADDR_LAST = (AW + 1)'(RAM_DP - 1);
    localparam logic [AW:0] ADDR_ONE  = (AW + 1)'(1);

    ilm_state_t       state_q, state_d;
    logic [AW:0]      addr_q,  addr_d;
    logic [1:0]       cnt_q,   cnt_d;
    logic [31:0]      buf_q,   buf_d;
    logic             pend_q,  pend_d;
    logic             last_q,  last_d;
    logic             err_q,   err_d;
    logic             done_q,  done_d;

    logic [ECC_W-1:0] ecc;
    logic [7:0]       upper;

    ilm_ecc_enc32 u_ecc (
        .data_i (buf_q),
        .ecc_o  (ecc)
    );

    // Next-state logic: FSM, byte lane packer, address counter, grant handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        last_d  = last_q;
        err_d   = err_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    pend_d  = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end

            ST_CLEAR: begin
                if (ilm_gnt) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_LOAD;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end

            ST_LOAD: begin
                if (pend_q) begin
                    // A packed word is waiting; the stream is stalled until granted
                    if (ilm_gnt) begin
                        pend_d = 1'b0;
                        buf_d  = '0;
                        addr_d = addr_q + ADDR_ONE;
                        last_d = 1'b0;
                        if (last_q) state_d = ST_FLUSH;
                    end
                end else if (s_valid) begin
                    if (addr_q == ADDR_END) begin
                        // ILM already full: drop the byte but keep draining
                        err_d = 1'b1;
                        if (s_last) state_d = ST_FLUSH;
                    end else begin
                        buf_d[{cnt_q, 3'b000} +: 8] = s_data;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3 || s_last) begin
                            pend_d = 1'b1;
                            last_d = s_last;
                        end
                        if (s_last) cnt_d = '0;
                    end
                end
            end

            ST_FLUSH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any partially packed word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Output decode; buffer is zero during CLEAR so wdata is zero there too
    always_comb begin
        upper     = HAS_ECC ? {1'b0, ecc} : 8'h00;
        s_ready   = (state_q == ST_LOAD) && !pend_q;
        ilm_cs    = (state_q == ST_CLEAR) || ((state_q == ST_LOAD) && pend_q);
        ilm_we    = ilm_cs;
        ilm_addr  = addr_q[AW-1:0];
        ilm_wdata = {upper, buf_q};
        busy      = (state_q == ST_CLEAR) || (state_q == ST_LOAD) ||
                    (state_q == ST_FLUSH);
        core_hold = busy;
        done      = done_q;
        err_ovf   = err_q;
    end

endmodule
